// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode seven-segment scanner with double-buffered data,
// per-digit enables and leading-zero blanking. Optional decimal points: SEG_SCAN_DP_EN.
module seg_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] Data,
    input  logic                    Load,
    input  logic [NUM_DIGITS-1:0]   Digit_En,
    input  logic                    Blank_Lead,
`ifdef SEG_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]   Dp,
    output logic                    DP,
`endif
    output logic [7:1]              C,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    Frame_Done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    run;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    pending;
    logic                    tc;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic                    upper_zero;
    logic                    dark;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tc        = (presc == PRE_LAST);
    assign frame_end = tc && (idx == '0);

    // run holds the pins dark for the first edge after reset so the first digit
    // lands on the second edge, keeping idx-to-pin latency at one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= IDX_LAST;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            presc <= tc ? '0 : presc + 1'b1;
            if (tc)
                idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (frame_end && Load) begin
            display <= Data;
            pending <= 1'b0;
        end else if (Load) begin
            shadow  <= Data;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end
    end

    always_comb begin
        cur_nib    = '0;
        upper_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx)
                cur_nib = display[4*k +: 4];
            if (k >= 32'(idx) && display[4*k +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        dark     = !run || !Digit_En[idx] || (Blank_Lead && upper_zero && idx != '0);
        seg_next = dark ? '1 : hex_to_seg(cur_nib);
        an_next  = dark ? '1 : ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C          <= '1;
            AN         <= '1;
            Frame_Done <= 1'b0;
        end else begin
            C          <= seg_next;
            AN         <= an_next;
            Frame_Done <= frame_end;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] display_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dp  <= '0;
            display_dp <= '0;
            DP         <= 1'b1;
        end else begin
            if (frame_end && Load)
                display_dp <= Dp;
            else if (Load)
                shadow_dp <= Dp;
            else if (frame_end && pending)
                display_dp <= shadow_dp;
            DP <= dark ? 1'b1 : ~display_dp[idx];
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int RD = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] c;
    } slot_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] c;
        logic       fd;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Data = '0;
    logic        Load = 1'b0;
    logic [3:0]  Digit_En = 4'hF;
    logic        Blank_Lead = 1'b0;
    logic [7:1]  C;
    logic [3:0]  AN;
    logic        Frame_Done;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  Dp = '0;
    logic        DP;
`endif

    int    checks = 0;
    int    errors = 0;
    slot_t sb[$];
    cyc_t  cq[$];

    localparam slot_t DARK = {4'b1111, 7'b1111111};

    seg_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Data       (Data),
        .Load       (Load),
        .Digit_En   (Digit_En),
        .Blank_Lead (Blank_Lead),
`ifdef SEG_SCAN_DP_EN
        .Dp         (Dp),
        .DP         (DP),
`endif
        .C          (C),
        .AN         (AN),
        .Frame_Done (Frame_Done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic slot_t lit(input int d, input logic [3:0] v);
        slot_t r;
        r.an = ~(4'b0001 << d);
        r.c  = seg(v);
        return r;
    endfunction

    function automatic void push_value(input logic [15:0] v);
        for (int d = ND - 1; d >= 0; d--)
            sb.push_back(lit(d, v[4*d +: 4]));
    endfunction

    task automatic wait_fd(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 40) begin
            @(negedge clk);
            n++;
            if (Frame_Done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic next_slot(input int n, output slot_t got);
        repeat (n) @(negedge clk);
        got = {AN, C};
    endtask

    task automatic pulse_load(input logic [15:0] v);
        Data = v;
        Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
    endtask

    task automatic test_reset;
        cyc_t e, got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({AN, C, Frame_Done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: AN=%b C=%b FD=%b expected 1111 1111111 0", AN, C, Frame_Done);
        end
        for (int k = 1; k <= 17; k++) begin
            e.an = (k == 1) ? 4'b1111 : (k <= 4) ? 4'b0111 : (k <= 8) ? 4'b1011 :
                   (k <= 12) ? 4'b1101 : (k <= 16) ? 4'b1110 : 4'b0111;
            e.c  = (k == 1) ? 7'b1111111 : 7'b1000000;
            e.fd = (k == 16);
            cq.push_back(e);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            e   = cq.pop_front();
            got = {AN, C, Frame_Done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_seq edge %0d: AN=%b C=%b FD=%b expected AN=%b C=%b FD=%b",
                         k, got.an, got.c, got.fd, e.an, e.c, e.fd);
            end
        end
    endtask

    task automatic test_frame_period;
        int n;
        int exp_gap[$];
        exp_gap.push_back(15);
        exp_gap.push_back(ND * RD);
        exp_gap.push_back(ND * RD);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (Frame_Done !== 1'b1 && n < 40);
            checks++;
            if (n !== exp_gap[0]) begin
                errors++;
                $display("FAIL frame_period %0d: gap=%0d expected %0d", i, n, exp_gap[0]);
            end
            void'(exp_gap.pop_front());
        end
        @(negedge clk);
        checks++;
        if (Frame_Done !== 1'b0) begin
            errors++;
            $display("FAIL frame_pulse_width: FD=%b expected 0", Frame_Done);
        end
    endtask

    task automatic test_load_mid_frame;
        bit ok;
        slot_t got, e;
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_mid sync: no Frame_Done expected 1"); end
        pulse_load(16'h3A5F);
        push_value(16'h0000);
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 1 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_mid old slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
        push_value(16'h3A5F);
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_mid sync2: no Frame_Done expected 1"); end
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 2 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_mid new slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
    endtask

    task automatic test_last_load_wins;
        bit ok;
        slot_t got, e;
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL last_load sync: no Frame_Done expected 1"); end
        push_value(16'h3A5F);
        pulse_load(16'h1111);
        @(negedge clk);
        got = {AN, C};
        pulse_load(16'h2222);
        for (int s = 0; s < 4; s++) begin
            if (s == 1) next_slot(3, got);
            else if (s > 1) next_slot(4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL last_load old slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
        push_value(16'h2222);
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL last_load sync2: no Frame_Done expected 1"); end
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 2 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL last_load new slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
    endtask

    task automatic test_coincident_load;
        bit ok;
        slot_t got, e;
        @(negedge clk);
        Data = 16'h9876;
        Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        checks++;
        if (Frame_Done !== 1'b1) begin
            errors++;
            $display("FAIL coincident boundary: FD=%b expected 1", Frame_Done);
        end
        push_value(16'h9876);
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 2 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL coincident slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
        push_value(16'h9876);
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL coincident sync: no Frame_Done expected 1"); end
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 2 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL coincident hold slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
    endtask

    task automatic test_blank_lead;
        bit ok;
        slot_t got, e;
        logic [15:0] vals [3];
        vals[0] = 16'h0040;
        vals[1] = 16'h0000;
        vals[2] = 16'h0102;
        Blank_Lead = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_fd(ok);
            checks++; if (!ok) begin errors++; $display("FAIL blank sync %0d: no Frame_Done expected 1", t); end
            pulse_load(vals[t]);
            case (t)
                0: begin sb.push_back(DARK); sb.push_back(DARK); sb.push_back(lit(1, 4'h4)); sb.push_back(lit(0, 4'h0)); end
                1: begin sb.push_back(DARK); sb.push_back(DARK); sb.push_back(DARK); sb.push_back(lit(0, 4'h0)); end
                default: begin sb.push_back(DARK); sb.push_back(lit(2, 4'h1)); sb.push_back(lit(1, 4'h0)); sb.push_back(lit(0, 4'h2)); end
            endcase
            wait_fd(ok);
            checks++; if (!ok) begin errors++; $display("FAIL blank sync2 %0d: no Frame_Done expected 1", t); end
            for (int s = 0; s < 4; s++) begin
                next_slot(s == 0 ? 2 : 4, got);
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL blank_lead %h slot %0d: AN=%b C=%b expected AN=%b C=%b", vals[t], s, got.an, got.c, e.an, e.c);
                end
            end
        end
        Blank_Lead = 1'b0;
    endtask

    task automatic test_digit_en;
        bit ok;
        slot_t got, e;
        Digit_En = 4'b1010;
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL digit_en sync: no Frame_Done expected 1"); end
        pulse_load(16'h4321);
        sb.push_back(lit(3, 4'h4)); sb.push_back(DARK); sb.push_back(lit(1, 4'h2)); sb.push_back(DARK);
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL digit_en sync2: no Frame_Done expected 1"); end
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 2 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL digit_en slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
        Digit_En = 4'hF;
    endtask

    task automatic test_reset_mid;
        bit ok;
        slot_t got, e;
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_mid sync: no Frame_Done expected 1"); end
        pulse_load(16'hBEEF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({AN, C, Frame_Done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid async: AN=%b C=%b FD=%b expected 1111 1111111 0", AN, C, Frame_Done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_value(16'h0000);
        wait_fd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_mid sync2: no Frame_Done expected 1"); end
        for (int s = 0; s < 4; s++) begin
            next_slot(s == 0 ? 2 : 4, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid slot %0d: AN=%b C=%b expected AN=%b C=%b", s, got.an, got.c, e.an, e.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_period();
        test_load_mid_frame();
        test_last_load_wins();
        test_coincident_load();
        test_blank_lead();
        test_digit_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
